// File: rtl/elevator_scan_controller.sv
// Single-car elevator controller with SCAN scheduling: latches calls, steps one floor
// every MOVE_CYCLES, stops at pending floors ahead and reverses only when none remain.
module elevator_scan_controller #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = $clog2(NUM_FLOORS),
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  door_hold,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [FLOOR_W-1:0]    next_floor,
  output logic                  dir_up,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending
);

  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;

  localparam int MT_W = (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MT_W-1:0] MOVE_RELOAD = MT_W'(MOVE_CYCLES - 1);
  localparam logic [DT_W-1:0] DOOR_RELOAD = DT_W'(DOOR_CYCLES - 1);

  state_t                  state, state_nxt;
  logic [FLOOR_W-1:0]      floor_nxt;
  logic                    dir_nxt;
  logic [NUM_FLOORS-1:0]   pending_nxt;
  logic                    arrived_nxt;
  logic [MT_W-1:0]         step_timer, step_nxt;
  logic [DT_W-1:0]         door_timer, door_nxt;

  logic                    req_ok;
  logic                    cur_call;
  logic                    step_hit;
  logic                    ahead;
  logic                    behind;
  logic [FLOOR_W-1:0]      step_floor;
  logic [NUM_FLOORS-1:0]   req_mask, cur_mask, step_mask;
  logic [NUM_FLOORS-1:0]   above_mask, below_mask;
  logic [NUM_FLOORS-1:0]   set_mask, clr_mask;

  // Call decode and SCAN look-ahead, all from registered state.
  always_comb begin
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above_mask[i] = (i > int'(current_floor));
      below_mask[i] = (i < int'(current_floor));
    end
    req_ok     = req_valid && (int'(req_floor) < NUM_FLOORS);
    req_mask   = req_ok ? (NUM_FLOORS'(1) << req_floor) : '0;
    cur_call   = req_ok && (req_floor == current_floor);
    step_floor = dir_up ? current_floor + FLOOR_W'(1) : current_floor - FLOOR_W'(1);
    cur_mask   = NUM_FLOORS'(1) << current_floor;
    step_mask  = NUM_FLOORS'(1) << step_floor;
    // A call landing on the same edge as the step still counts for the new floor.
    step_hit   = pending[step_floor] || (req_ok && (req_floor == step_floor));
    ahead      = |(pending & (dir_up ? above_mask : below_mask));
    behind     = |(pending & (dir_up ? below_mask : above_mask));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      current_floor <= '0;
      dir_up        <= 1'b1;
      pending       <= '0;
      arrived       <= 1'b0;
      step_timer    <= '0;
      door_timer    <= '0;
    end else begin
      state         <= state_nxt;
      current_floor <= floor_nxt;
      dir_up        <= dir_nxt;
      pending       <= pending_nxt;
      arrived       <= arrived_nxt;
      step_timer    <= step_nxt;
      door_timer    <= door_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    floor_nxt   = current_floor;
    dir_nxt     = dir_up;
    step_nxt    = step_timer;
    door_nxt    = door_timer;
    arrived_nxt = 1'b0;
    set_mask    = req_mask;
    clr_mask    = '0;
    case (state)
      IDLE: begin
        if (pending[current_floor]) begin
          state_nxt   = DOOR_OPEN;
          door_nxt    = DOOR_RELOAD;
          arrived_nxt = 1'b1;
          clr_mask    = cur_mask;
        end else if (ahead) begin
          state_nxt = MOVING;
          step_nxt  = MOVE_RELOAD;
        end else if (behind) begin
          dir_nxt   = ~dir_up;
          state_nxt = MOVING;
          step_nxt  = MOVE_RELOAD;
        end
      end
      MOVING: begin
        if (step_timer != '0) begin
          step_nxt = step_timer - MT_W'(1);
        end else begin
          floor_nxt = step_floor;
          if (step_hit) begin
            state_nxt   = DOOR_OPEN;
            door_nxt    = DOOR_RELOAD;
            arrived_nxt = 1'b1;
            clr_mask    = step_mask;
          end else begin
            step_nxt = MOVE_RELOAD;
          end
        end
      end
      DOOR_OPEN: begin
        // A call for the floor we are standing at just keeps the door open.
        if (cur_call) set_mask = '0;
        if (door_hold || cur_call) begin
          door_nxt = DOOR_RELOAD;
        end else if (door_timer != '0) begin
          door_nxt = door_timer - DT_W'(1);
        end else if (ahead) begin
          state_nxt = MOVING;
          step_nxt  = MOVE_RELOAD;
        end else if (behind) begin
          dir_nxt   = ~dir_up;
          state_nxt = MOVING;
          step_nxt  = MOVE_RELOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    pending_nxt = (pending | set_mask) & ~clr_mask;
  end

  always_comb begin
    moving     = (state == MOVING);
    door_open  = (state == DOOR_OPEN);
    next_floor = (state == MOVING) ? step_floor : current_floor;
  end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Directed self-checking bench for elevator_scan_controller: an 8-floor car for the
// scheduling/dwell/reset scenarios and a 6-floor car for range and boundary checks.
module tb_elevator_scan_controller;

  logic       clk = 1'b0;
  logic       rst;
  always #5 clk = ~clk;

  logic       req_valid, door_hold;
  logic [2:0] req_floor;
  logic [2:0] cur, nxt;
  logic       dir_up, moving, door_open, arrived;
  logic [7:0] pending;

  logic       req_valid6, door_hold6;
  logic [2:0] req_floor6;
  logic [2:0] cur6, nxt6;
  logic       dir6, moving6, door6, arrived6;
  logic [5:0] pending6;

  int checks   = 0;
  int failures = 0;
  int cnt;

  elevator_scan_controller #(.NUM_FLOORS(8), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .door_hold(door_hold), .current_floor(cur), .next_floor(nxt), .dir_up(dir_up),
    .moving(moving), .door_open(door_open), .arrived(arrived), .pending(pending)
  );

  elevator_scan_controller #(.NUM_FLOORS(6), .MOVE_CYCLES(4), .DOOR_CYCLES(3)) dut6 (
    .clk(clk), .rst(rst), .req_valid(req_valid6), .req_floor(req_floor6),
    .door_hold(door_hold6), .current_floor(cur6), .next_floor(nxt6), .dir_up(dir6),
    .moving(moving6), .door_open(door6), .arrived(arrived6), .pending(pending6)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic call(input logic [2:0] f);
    req_valid = 1'b1;
    req_floor = f;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic call6(input logic [2:0] f);
    req_valid6 = 1'b1;
    req_floor6 = f;
    tick();
    req_valid6 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid  = 1'b0; req_floor  = '0; door_hold  = 1'b0;
    req_valid6 = 1'b0; req_floor6 = '0; door_hold6 = 1'b0;
    do_reset();

    // Reset values.
    check("rst_floor",   32'(cur), 0);
    check("rst_next",    32'(nxt), 0);
    check("rst_dir",     32'(dir_up), 1);
    check("rst_moving",  32'(moving), 0);
    check("rst_door",    32'(door_open), 0);
    check("rst_arrived", 32'(arrived), 0);
    check("rst_pending", 32'(pending), 0);

    // Floor 0 -> 2: moving after E1, floor 1 after E5, arrival after E9.
    call(3'd2);
    check("s1_pend_e0",   32'(pending), 'h04);
    check("s1_idle_e0",   32'(moving), 0);
    tick();
    check("s1_mov_e1",    32'(moving), 1);
    check("s1_next_e1",   32'(nxt), 1);
    check("s1_floor_e1",  32'(cur), 0);
    ticks(4);
    check("s1_floor_e5",  32'(cur), 1);
    check("s1_mov_e5",    32'(moving), 1);
    ticks(4);
    check("s1_floor_e9",  32'(cur), 2);
    check("s1_door_e9",   32'(door_open), 1);
    check("s1_arr_e9",    32'(arrived), 1);
    check("s1_mov_e9",    32'(moving), 0);
    check("s1_pend_e9",   32'(pending), 0);
    tick();
    check("s1_arr_e10",   32'(arrived), 0);
    check("s1_door_e10",  32'(door_open), 1);
    ticks(2);
    check("s1_door_e12",  32'(door_open), 0);
    check("s1_mov_e12",   32'(moving), 0);
    check("s1_floor_e12", 32'(cur), 2);

    // Call 5, then 3 while at floor 1: stop at 3 first, keep going up to 5.
    do_reset();
    call(3'd5);
    tick();
    ticks(4);
    check("s2_floor_e5",  32'(cur), 1);
    call(3'd3);
    check("s2_pend_e6",   32'(pending), 'h28);
    ticks(6);
    check("s2_floor_e12", 32'(cur), 2);
    tick();
    check("s2_floor_e13", 32'(cur), 3);
    check("s2_arr_e13",   32'(arrived), 1);
    check("s2_door_e13",  32'(door_open), 1);
    check("s2_dir_e13",   32'(dir_up), 1);
    check("s2_pend_e13",  32'(pending), 'h20);
    ticks(3);
    check("s2_mov_e16",   32'(moving), 1);
    check("s2_door_e16",  32'(door_open), 0);
    check("s2_next_e16",  32'(nxt), 4);
    check("s2_dir_e16",   32'(dir_up), 1);
    ticks(8);
    check("s2_floor_e24", 32'(cur), 5);
    check("s2_arr_e24",   32'(arrived), 1);
    check("s2_dir_e24",   32'(dir_up), 1);
    check("s2_pend_e24",  32'(pending), 0);

    // Pending {6,1} while passing floor 4 upward: service 6, reverse, service 1.
    do_reset();
    call(3'd6);
    ticks(9);
    check("s3_floor_e9",  32'(cur), 2);
    call(3'd1);
    check("s3_pend_e10",  32'(pending), 'h42);
    ticks(7);
    check("s3_floor_e17", 32'(cur), 4);
    check("s3_mov_e17",   32'(moving), 1);
    check("s3_door_e17",  32'(door_open), 0);
    check("s3_dir_e17",   32'(dir_up), 1);
    ticks(8);
    check("s3_floor_e25", 32'(cur), 6);
    check("s3_arr_e25",   32'(arrived), 1);
    check("s3_pend_e25",  32'(pending), 'h02);
    check("s3_dir_e25",   32'(dir_up), 1);
    ticks(3);
    check("s3_dir_e28",   32'(dir_up), 0);
    check("s3_mov_e28",   32'(moving), 1);
    check("s3_next_e28",  32'(nxt), 5);
    ticks(20);
    check("s3_floor_e48", 32'(cur), 1);
    check("s3_arr_e48",   32'(arrived), 1);
    check("s3_pend_e48",  32'(pending), 0);
    ticks(3);
    check("s3_door_e51",  32'(door_open), 0);
    check("s3_mov_e51",   32'(moving), 0);
    check("s3_dir_e51",   32'(dir_up), 0);

    // door_hold for 10 cycles: door open for 10+3 cycles in total.
    call(3'd1);
    check("s4_pend_f0",   32'(pending), 'h02);
    tick();
    check("s4_door_f1",   32'(door_open), 1);
    check("s4_arr_f1",    32'(arrived), 1);
    check("s4_pend_f1",   32'(pending), 0);
    cnt = 1;
    door_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (door_open) cnt++;
    end
    door_hold = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (door_open) cnt++;
    end
    check("s4_hold_cycles", 32'(cnt), 13);

    // Same-floor call during dwell extends it and leaves pending clear.
    call(3'd1);
    tick();
    check("s4_door_g1",   32'(door_open), 1);
    req_valid = 1'b1;
    req_floor = 3'd1;
    tick();
    req_valid = 1'b0;
    check("s4_pend_g2",   32'(pending), 0);
    check("s4_door_g2",   32'(door_open), 1);
    ticks(2);
    check("s4_door_g4",   32'(door_open), 1);
    tick();
    check("s4_door_g5",   32'(door_open), 0);
    check("s4_pend_g5",   32'(pending), 0);

    // Six-floor car: out-of-range calls ignored, travel to top and bottom.
    check("s5_floor_init", 32'(cur6), 0);
    req_valid6 = 1'b1;
    req_floor6 = 3'd7;
    tick();
    req_floor6 = 3'd6;
    tick();
    req_valid6 = 1'b0;
    check("s5_pend_oor",  32'(pending6), 0);
    ticks(3);
    check("s5_mov_oor",   32'(moving6), 0);
    check("s5_floor_oor", 32'(cur6), 0);
    call6(3'd5);
    check("s5_pend_top",  32'(pending6), 'h20);
    ticks(20);
    check("s5_floor_h20", 32'(cur6), 4);
    tick();
    check("s5_floor_h21", 32'(cur6), 5);
    check("s5_arr_h21",   32'(arrived6), 1);
    ticks(3);
    check("s5_mov_h24",   32'(moving6), 0);
    check("s5_door_h24",  32'(door6), 0);
    check("s5_floor_h24", 32'(cur6), 5);
    check("s5_next_h24",  32'(nxt6), 5);
    call6(3'd7);
    check("s5_pend_oor2", 32'(pending6), 0);
    call6(3'd0);
    tick();
    check("s5_mov_i1",    32'(moving6), 1);
    check("s5_dir_i1",    32'(dir6), 0);
    check("s5_next_i1",   32'(nxt6), 4);
    ticks(20);
    check("s5_floor_i21", 32'(cur6), 0);
    check("s5_arr_i21",   32'(arrived6), 1);
    ticks(3);
    check("s5_mov_i24",   32'(moving6), 0);
    check("s5_floor_i24", 32'(cur6), 0);

    // Reset mid-move at floor 3 with a further call in flight.
    do_reset();
    call(3'd6);
    ticks(13);
    check("s6_floor_e13", 32'(cur), 3);
    check("s6_mov_e13",   32'(moving), 1);
    req_valid = 1'b1;
    req_floor = 3'd5;
    tick();
    req_valid = 1'b0;
    check("s6_pend_e14",  32'(pending), 'h60);
    #1 rst = 1'b0;
    #1;
    check("s6_rst_floor", 32'(cur), 0);
    check("s6_rst_next",  32'(nxt), 0);
    check("s6_rst_dir",   32'(dir_up), 1);
    check("s6_rst_mov",   32'(moving), 0);
    check("s6_rst_door",  32'(door_open), 0);
    check("s6_rst_arr",   32'(arrived), 0);
    check("s6_rst_pend",  32'(pending), 0);
    #3 rst = 1'b1;
    ticks(5);
    check("s6_post_floor", 32'(cur), 0);
    check("s6_post_mov",   32'(moving), 0);
    check("s6_post_door",  32'(door_open), 0);
    check("s6_post_pend",  32'(pending), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
